// File: rtl/pwm_pkg.sv
// Shared constants, step FSM state type and saturating step helper for the
// PWM duty-cycle controller.
package pwm_pkg;

  localparam int unsigned DUTY_W     = 4;
  localparam int unsigned DUTY_MAX   = 10;
  localparam int unsigned DUTY_RESET = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FIRST,
    ST_REPEAT,
    ST_LOCKOUT
  } step_state_e;

  // One step up or down, clamped to [0, DUTY_MAX].
  function automatic logic [DUTY_W-1:0] duty_step(input logic [DUTY_W-1:0] cur,
                                                  input logic              up);
    logic [DUTY_W-1:0] res;
    res = cur;
    if (up) begin
      if (cur != DUTY_W'(DUTY_MAX)) res = cur + DUTY_W'(1);
    end else begin
      if (cur != '0) res = cur - DUTY_W'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stable-level counter for one raw push-button.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_level
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;

  // Level flips only after DEBOUNCE_CYC consecutive cycles of disagreement.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/pwm_duty_controller.sv
// Button-driven duty setpoint with debounce, hold-to-repeat, saturation and
// period-boundary commit into the PWM comparator.
module pwm_duty_controller
  import pwm_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter int unsigned REPEAT_DELAY = 32,
  parameter int unsigned REPEAT_RATE  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              increase_duty,
  input  logic              decrease_duty,
  input  logic              period_end,
  output logic [DUTY_W-1:0] duty_target,
  output logic [DUTY_W-1:0] duty_active,
  output logic              step_pulse,
  output logic              at_max,
  output logic              at_min
);

  localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);

  logic              w_inc_lvl;
  logic              w_dec_lvl;
  logic              w_both;
  logic              w_pressed;
  logic              w_held;
  logic              w_step_ok;
  logic [DUTY_W-1:0] w_duty_next;

  step_state_e       r_state;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_step_req;
  logic              r_step_up;
  logic [DUTY_W-1:0] r_duty_target;
  logic [DUTY_W-1:0] r_duty_active;
  logic              r_step_pulse;
  logic              r_at_max;
  logic              r_at_min;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_inc (
    .clk     (clk),
    .reset   (reset),
    .i_btn   (increase_duty),
    .o_level (w_inc_lvl)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_dec (
    .clk     (clk),
    .reset   (reset),
    .i_btn   (decrease_duty),
    .o_level (w_dec_lvl)
  );

  assign w_both      = w_inc_lvl & w_dec_lvl;
  assign w_pressed   = w_inc_lvl ^ w_dec_lvl;
  assign w_held      = r_step_up ? w_inc_lvl : w_dec_lvl;
  assign w_duty_next = r_step_req ? duty_step(r_duty_target, r_step_up) : r_duty_target;
  assign w_step_ok   = (w_duty_next != r_duty_target);

  // Step FSM: issues a one-cycle step request that the datapath applies next edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_hold_cnt <= '0;
      r_step_req <= 1'b0;
      r_step_up  <= 1'b0;
    end else begin
      r_step_req <= 1'b0;
      if (w_both) begin
        r_state    <= ST_LOCKOUT;
        r_hold_cnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_pressed) begin
              r_state    <= ST_FIRST;
              r_hold_cnt <= '0;
              r_step_req <= 1'b1;
              r_step_up  <= w_inc_lvl;
            end
          end
          ST_FIRST: begin
            if (!w_held) begin
              r_state    <= ST_IDLE;
              r_hold_cnt <= '0;
            end else if (r_hold_cnt == HOLD_W'(REPEAT_DELAY - 1)) begin
              r_state    <= ST_REPEAT;
              r_hold_cnt <= '0;
              r_step_req <= 1'b1;
            end else begin
              r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
            end
          end
          ST_REPEAT: begin
            if (!w_held) begin
              r_state    <= ST_IDLE;
              r_hold_cnt <= '0;
            end else if (r_hold_cnt == HOLD_W'(REPEAT_RATE - 1)) begin
              r_hold_cnt <= '0;
              r_step_req <= 1'b1;
            end else begin
              r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
            end
          end
          ST_LOCKOUT: begin
            if (!w_inc_lvl && !w_dec_lvl) r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Setpoint, flags and shadow commit; duty_active takes the pre-edge target.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_duty_target <= DUTY_W'(DUTY_RESET);
      r_duty_active <= DUTY_W'(DUTY_RESET);
      r_step_pulse  <= 1'b0;
      r_at_max      <= (DUTY_RESET == DUTY_MAX);
      r_at_min      <= (DUTY_RESET == 0);
    end else begin
      r_duty_target <= w_duty_next;
      r_step_pulse  <= w_step_ok;
      r_at_max      <= (w_duty_next == DUTY_W'(DUTY_MAX));
      r_at_min      <= (w_duty_next == '0);
      if (period_end) r_duty_active <= r_duty_target;
    end
  end

  assign duty_target = r_duty_target;
  assign duty_active = r_duty_active;
  assign step_pulse  = r_step_pulse;
  assign at_max      = r_at_max;
  assign at_min      = r_at_min;

endmodule
